// File: rtl/keypad_scan4x4_pkg.sv
// Shared types, constants and row classification for the 4x4 keypad scanner.
package keypad_scan4x4_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ROW_EMPTY  = 2'd0,
    ROW_SINGLE = 2'd1,
    ROW_MULTI  = 2'd2
  } row_kind_t;

  typedef struct packed {
    row_kind_t  kind;
    logic [1:0] idx;
  } row_hit_t;

  // Active-low one-hot column drives; column 0 is the left column.
  localparam logic [3:0] COL_0    = 4'b1110;
  localparam logic [3:0] COL_1    = 4'b1101;
  localparam logic [3:0] COL_2    = 4'b1011;
  localparam logic [3:0] COL_3    = 4'b0111;
  localparam logic [3:0] COL_IDLE = COL_0;

  // Rows are pulled up, so all-ones means nothing pressed.
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    logic [3:0] d;
    case (c)
      2'd0:    d = COL_0;
      2'd1:    d = COL_1;
      2'd2:    d = COL_2;
      default: d = COL_3;
    endcase
    return d;
  endfunction

  // Two or more low rows cannot be resolved to one key (ghosting), so they
  // are reported as MULTI and the FSM treats them like an empty sample.
  function automatic row_hit_t row_decode(input logic [3:0] rs);
    row_hit_t h;
    h.kind = ROW_MULTI;
    h.idx  = 2'd0;
    case (rs)
      4'b1111: h.kind = ROW_EMPTY;
      4'b1110: begin h.kind = ROW_SINGLE; h.idx = 2'd0; end
      4'b1101: begin h.kind = ROW_SINGLE; h.idx = 2'd1; end
      4'b1011: begin h.kind = ROW_SINGLE; h.idx = 2'd2; end
      4'b0111: begin h.kind = ROW_SINGLE; h.idx = 2'd3; end
      default: ;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/keypad_scan4x4_sync2_bus.sv
// Two-flop synchronizer for a bus of asynchronous inputs, with a settable
// reset value so idle-high buses come out of reset looking idle.
module sync2_bus #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_rst_val,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage capture of the asynchronous bus.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= i_rst_val;
      r_sync <= i_rst_val;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scan4x4.sv
// 4x4 matrix keypad scanner with debounce: walks the columns, samples the
// synchronized rows once per dwell period, and reports debounced presses.
module keypad_scan4x4
  import keypad_scan4x4_pkg::*;
#(
  parameter int unsigned SCAN_TICKS       = 1000,
  parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_down
);

  localparam int unsigned TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_SAMPLES);

  logic [3:0]    w_rs;
  logic          w_sample;
  row_hit_t      w_hit;
  logic [1:0]    w_c_next;
  logic [CW-1:0] w_cnt_inc;
  logic          w_accept;

  logic [TW-1:0] r_tick;
  state_t        r_state;
  logic [1:0]    r_c;
  logic [1:0]    r_r;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_col;
  logic [3:0]    r_key;
  logic          r_key_valid;
  logic          r_key_down;

  sync2_bus #(.WIDTH(4)) u_row_sync (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_rst_val (ROWS_IDLE),
    .i_d       (row),
    .o_q       (w_rs)
  );

  assign w_sample  = (r_tick == TICK_LAST);
  assign w_hit     = row_decode(w_rs);
  assign w_c_next  = r_c + 2'd1;
  assign w_cnt_inc = (r_cnt == CNT_DONE) ? r_cnt : r_cnt + CW'(1);

  // Accept can come straight from SCAN when one sample is enough, so it is
  // resolved ahead of the per-state handling.
  assign w_accept = w_sample && (w_hit.kind == ROW_SINGLE) &&
                    (((r_state == ST_SCAN) && (DEBOUNCE_SAMPLES == 1)) ||
                     ((r_state == ST_DEBOUNCE) && (w_hit.idx == r_r) &&
                      (w_cnt_inc == CNT_DONE)));

  // Free-running sample timebase, independent of FSM state.
  always_ff @(posedge clk) begin
    if (rst)
      r_tick <= '0;
    else if (w_sample)
      r_tick <= '0;
    else
      r_tick <= r_tick + TW'(1);
  end

  // Scan/debounce/held FSM with registered column and key outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SCAN;
      r_c         <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      r_col       <= COL_IDLE;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_accept) begin
        r_r         <= w_hit.idx;
        r_key       <= {w_hit.idx, r_c};
        r_key_valid <= 1'b1;
        r_key_down  <= 1'b1;
        r_cnt       <= '0;
        r_state     <= ST_HELD;
      end else if (w_sample) begin
        case (r_state)
          ST_SCAN: begin
            if (w_hit.kind == ROW_SINGLE) begin
              r_r     <= w_hit.idx;
              r_cnt   <= CW'(1);
              r_state <= ST_DEBOUNCE;
            end else begin
              r_c   <= w_c_next;
              r_col <= col_drive(w_c_next);
            end
          end
          ST_DEBOUNCE: begin
            if ((w_hit.kind == ROW_SINGLE) && (w_hit.idx == r_r)) begin
              r_cnt <= w_cnt_inc;
            end else begin
              r_cnt   <= '0;
              r_c     <= w_c_next;
              r_col   <= col_drive(w_c_next);
              r_state <= ST_SCAN;
            end
          end
          ST_HELD: begin
            if (!w_rs[r_r]) begin
              r_cnt <= '0;
            end else if (w_cnt_inc == CNT_DONE) begin
              r_cnt      <= '0;
              r_key_down <= 1'b0;
              r_c        <= w_c_next;
              r_col      <= col_drive(w_c_next);
              r_state    <= ST_SCAN;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: r_state <= ST_SCAN;
        endcase
      end
    end
  end

  assign col       = r_col;
  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign key_down  = r_key_down;

endmodule

// File: doc/keypad_scan4x4.md
# keypad_scan4x4

Scans a 4x4 matrix keypad and debounces it, producing a 4-bit key code 0–15 together with a one-cycle strobe for each new press. The block sits directly upstream of the 4-bit-to-6-bit code decoder. Its `key` output drives that decoder's 4-bit input. The block runs entirely in the system clock domain and contains a synchronizer for the asynchronous row inputs.

## Interface
- `SCAN_TICKS`, default 1000: clock cycles per column dwell/sample period T. Must be ≥ 4.
- `DEBOUNCE_SAMPLES`, default 4: consecutive matching samples required to accept a press or a release. Must be ≥ 1.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `row`  in  4  keypad rows, active-low, externally pulled up, asynchronous. `row[0]` is the top row.
- `col`  out 4  column drive, active-low one-hot. `col[0]` is the left column.
- `key`  out 4  code of the last accepted key, `4*r + c`. Holds its value until the next accepted press.
- `key_valid` out 1  one-cycle pulse when a new press is accepted.
- `key_down`  out 1  high while an accepted key remains debounced-held.

## Operation
- Row inputs pass through a 2-flop synchronizer. All decisions use the synchronized value `rs`.
- A tick counter runs from 0 to `SCAN_TICKS-1` and wraps. A "sample" happens on the cycle where count == `SCAN_TICKS-1`.
- A sample is a *single hit* when exactly one bit of `rs` is 0. It is *empty* when `rs` == 4'b1111. Any other pattern (two or more rows low) is *multi*; multi is treated as empty (ghost rejection).
- The FSM has three states: SCAN, DEBOUNCE, HELD.
- **SCAN**
  - Drives column index c.
  - On a sample with a single hit at row r: latch r and c, set the match count to 1, go to DEBOUNCE. If `DEBOUNCE_SAMPLES`==1, go straight to accept.
  - On an empty or multi sample: c ← (c+1) mod 4, stay in SCAN.
- **DEBOUNCE**
  - Column c stays driven.
  - Sample is a single hit at the same r: increment the match count. When the count reaches `DEBOUNCE_SAMPLES`, accept.
  - Any other sample: c ← (c+1) mod 4, go to SCAN. No outputs change.
- **Accept**
  - On the cycle after the sample: `key` ← `{r[1:0], c[1:0]}`, `key_valid` = 1 for exactly one cycle, `key_down` ← 1.
  - The FSM enters HELD with the release count at 0.
- **HELD**
  - Column c stays driven.
  - An empty or multi sample increments the release count. A sample with any low row on the held row clears it.
  - When the release count reaches `DEBOUNCE_SAMPLES`: `key_down` ← 0 on the next cycle, c ← (c+1) mod 4, go to SCAN.
  - A second key pressed in another column is not seen while in HELD; there is no rollover.
- The tick counter is never reset by state changes. Every state transition happens only on a sample cycle.
- Column wrap order: 1110 → 1101 → 1011 → 0111 → 1110.

## Timing
- Reset values, applied the cycle after `rst` is sampled high:
  - `col` = 4'b1110, `key` = 0, `key_valid` = 0, `key_down` = 0.
  - FSM = SCAN, c = 0, tick count = 0, match/release counts = 0, synchronizer flops = 4'b1111.
- Reset asserted mid-operation (any state) overrides everything. A pending `key_valid` is suppressed.
- Synchronizer latency is 2 cycles. `col` changes the cycle after a sample, so the new column settles for `SCAN_TICKS-1` cycles before its next sample. This is the reason for `SCAN_TICKS` ≥ 4.
- Press latency: the first hit sample is at cycle k. `key_valid` is high at cycle k + (`DEBOUNCE_SAMPLES`-1)·`SCAN_TICKS` + 1.
- Release latency: the first empty sample is at cycle m. `key_down` falls at cycle m + (`DEBOUNCE_SAMPLES`-1)·`SCAN_TICKS` + 1.
- `key` is stable at least from the `key_valid` cycle until the next `key_valid`.
- Counter widths:
  - Tick counter: `$clog2(SCAN_TICKS)`.
  - Match/release counters: `$clog2(DEBOUNCE_SAMPLES+1)`.
  - Counters saturate and never wrap.

## Structure
- A shared package/header holds:
  - FSM state encodings: SCAN = 2'd0, DEBOUNCE = 2'd1, HELD = 2'd2.
  - Column one-hot constants, `COL_IDLE` = 4'b1110.
  - The row-decode function that classifies `rs` as empty / single(r) / multi.
- Sub-module `sync2_bus`: a parameterized-width 2-flop synchronizer with a reset value input. It is used for `row`.
- The rest is one module: tick counter, FSM, match/release counters, output registers.

## Test plan
All scenarios use `SCAN_TICKS`=4, `DEBOUNCE_SAMPLES`=3.
- Reset then idle (`row`=1111): outputs reset; `col` steps 1110→1101→1011→0111→1110, each value held 4 cycles; `key_valid` never asserts.
- Hold `row[2]`=0 while `col[1]` is low: exactly one `key_valid` pulse, 9 cycles after the first hit sample; `key`=9 and `key_down`=1 on that cycle; `col` frozen at 1101.
- Bounce: row low for 2 samples, then high: no `key_valid`; `key` unchanged; `col` advances to 1011.
- Ghost: `row`=1010 during `col`=0111: treated as empty; no `key_valid`; scan continues.
- Release after the accepted key 9: rows high for 3 samples → `key_down` falls; `key` stays 9; `col` advances to 1011. A row bounce after 2 empty samples restarts the release count.
- Assert `rst` for 1 cycle in HELD: the next cycle shows the reset values; then idle scanning resumes.
